riscv_v_mask_packer: RTL and testbench

Collects per-byte flag vectors produced by the vector adder (compare results, carry-out, overflow) beat by beat. Extracts one bit per element according to element size and packs them into a dense mask register value (element *i* → bit *i*). Sits between the adder flag outputs and the vector register file mask writeback port. Used by vmseq/vmsne/vmslt/vmsgt, vmadc/vmsbc and similar mask-producing instructions. Accepts input with a valid/ready handshake and presents a completed mask with a valid/ready handshake.

---
 rtl/riscv_v_mask_packer.sv | 157 +++++++++++++++
 tb/tb_riscv_v_mask_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_mask_packer.sv
// Packs per-byte adder flags into a dense element mask (element i -> bit i); RISCV_V_MASK_TAIL_ONES_EN makes tail bits read 1.
// Latency: out_valid rises the cycle after the completing beat; every packet spends at least one cycle in DONE.
// Backpressure: in_ready is low while a finished mask waits for out_ready; upstream holds its beat.
module riscv_v_mask_packer #(
  parameter int DATA_BYTES = 16,
  parameter int MASK_BITS  = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_BYTES-1:0]      in_flags,
  input  logic                       in_sel_msb,
  input  logic [3:0]                 in_osize,
  input  logic [$clog2(MASK_BITS):0] in_vl,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MASK_BITS-1:0]       out_mask,
  output logic [$clog2(MASK_BITS):0] out_count
);
  localparam int AW = $clog2(MASK_BITS);
  localparam int IW = AW + 1;
  localparam int PW = AW + 2;

  typedef enum logic {ACCUM, DONE} state_t;

  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        vl_q;
  logic [1:0]           esz_q;
  logic                 sel_q;
  logic [MASK_BITS-1:0] acc_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic                  beat_fire;
  logic                  first_beat;
  logic                  sel_eff;
  logic                  done_beat;
  logic [1:0]            esz_in;
  logic [1:0]            esz_eff;
  logic [IW-1:0]         vl_in;
  logic [IW-1:0]         vl_eff;
  logic [PW-1:0]         epb;
  logic [PW-1:0]         idx_next;
  logic [DATA_BYTES-1:0] elem_bits;
  logic [MASK_BITS-1:0]  acc_nxt;

  assign beat_fire  = in_valid & in_ready_q;
  assign first_beat = (idx_q == '0);

  // esz is log2 of the element size in bytes
  always_comb begin
    esz_in = 2'd0;
    case (1'b1)
      in_osize[3]: esz_in = 2'd3;
      in_osize[2]: esz_in = 2'd2;
      in_osize[1]: esz_in = 2'd1;
      in_osize[0]: esz_in = 2'd0;
      default:     esz_in = 2'd0;
    endcase
  end

  assign vl_in   = (in_vl > IW'(MASK_BITS)) ? IW'(MASK_BITS) : in_vl;
  assign esz_eff = first_beat ? esz_in     : esz_q;
  assign sel_eff = first_beat ? in_sel_msb : sel_q;
  assign vl_eff  = first_beat ? vl_in      : vl_q;
  assign epb     = PW'(DATA_BYTES) >> esz_eff;

  always_comb begin
    elem_bits = '0;
    case (esz_eff)
      2'd0: elem_bits = in_flags;
      2'd1: for (int j = 0; j < DATA_BYTES / 2; j++)
              elem_bits[j] = in_flags[2 * j + (sel_eff ? 1 : 0)];
      2'd2: for (int j = 0; j < DATA_BYTES / 4; j++)
              elem_bits[j] = in_flags[4 * j + (sel_eff ? 3 : 0)];
      default: for (int j = 0; j < DATA_BYTES / 8; j++)
              elem_bits[j] = in_flags[8 * j + (sel_eff ? 7 : 0)];
    endcase
  end

  // Elements at or past vl are dropped; vl never exceeds MASK_BITS so the index fits.
  always_comb begin
    acc_nxt = acc_q;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if ((PW'(j) < epb) && ((PW'(idx_q) + PW'(j)) < PW'(vl_eff)))
        acc_nxt[AW'(idx_q + IW'(j))] = elem_bits[j];
    end
  end

  assign idx_next  = PW'(idx_q) + epb;
  assign done_beat = in_last | (idx_next >= PW'(vl_eff)) | (idx_next >= PW'(MASK_BITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      idx_q       <= '0;
      vl_q        <= '0;
      esz_q       <= 2'd0;
      sel_q       <= 1'b0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (beat_fire) begin
            acc_q <= acc_nxt;
            idx_q <= idx_next[IW-1:0];
            if (first_beat) begin
              esz_q <= esz_in;
              sel_q <= in_sel_msb;
              vl_q  <= vl_in;
            end
            if (done_beat) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = vl_q;

`ifdef RISCV_V_MASK_TAIL_ONES_EN
  logic [MASK_BITS-1:0] tail_ones;

  always_comb begin
    tail_ones = '0;
    for (int b = 0; b < MASK_BITS; b++)
      tail_ones[b] = (PW'(b) >= PW'(vl_q));
  end

  // Tail fill only on a presented mask so idle/reset output stays zero.
  assign out_mask = acc_q | (out_valid_q ? tail_ones : '0);
`else
  assign out_mask = acc_q;
`endif

endmodule

// File: tb/tb_riscv_v_mask_packer.sv
// Randomized bench for riscv_v_mask_packer against a packet-level mask model.
module tb_riscv_v_mask_packer;
  localparam int DB = 16;
  localparam int MB = 128;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DB-1:0] in_flags;
  logic          in_sel_msb;
  logic [3:0]    in_osize;
  logic [IW-1:0] in_vl;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [MB-1:0] out_mask;
  logic [IW-1:0] out_count;

  riscv_v_mask_packer #(.DATA_BYTES(DB), .MASK_BITS(MB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flags(in_flags),
    .in_sel_msb(in_sel_msb), .in_osize(in_osize), .in_vl(in_vl), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_mode = 1;  // 0 hold low, 1 hold high, 2 random
  logic [MB-1:0] exp_mask_q[$];
  int            exp_cnt_q[$];
  logic [DB-1:0] pkt_fl[$];

  task automatic check(string name, logic [MB-1:0] act, logic [MB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int ebytes(logic [3:0] os);
    if (os[3]) return 8;
    if (os[2]) return 4;
    if (os[1]) return 2;
    return 1;
  endfunction

  // Whole-packet mask from the first beat's parameters and the flag beats.
  function automatic logic [MB-1:0] model(logic [3:0] os, bit sel, int vl, logic [DB-1:0] fl[$]);
    int e = ebytes(os);
    int epb = DB / e;
    int v = (vl > MB) ? MB : vl;
    int idx = 0;
    logic [MB-1:0] m = '0;
    for (int b = 0; b < fl.size(); b++) begin
      for (int j = 0; j < epb; j++)
        if (idx + j < v) m[idx + j] = fl[b][j * e + (sel ? e - 1 : 0)];
      idx += epb;
    end
`ifdef RISCV_V_MASK_TAIL_ONES_EN
    for (int i = v; i < MB; i++) m[i] = 1'b1;
`endif
    return m;
  endfunction

  task automatic drive_beat(logic [DB-1:0] fl, logic [3:0] os, bit sel, int vl, bit last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_flags = fl; in_osize = os; in_sel_msb = sel;
    in_vl = IW'(vl); in_last = last;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", MB'(in_ready), MB'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Later beats carry junk size/sel/vl that the block must ignore.
  task automatic send_packet(logic [3:0] os, bit sel, int vl, bit last_final);
    exp_mask_q.push_back(model(os, sel, vl, pkt_fl));
    exp_cnt_q.push_back((vl > MB) ? MB : vl);
    for (int k = 0; k < pkt_fl.size(); k++) begin
      if (k == 0)
        drive_beat(pkt_fl[k], os, sel, vl, (pkt_fl.size() == 1) ? last_final : 1'b0);
      else
        drive_beat(pkt_fl[k], 4'b0001 << $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 140), (k == pkt_fl.size() - 1) ? last_final : 1'b0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_mask_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", MB'(exp_mask_q.size()), MB'(0));
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Every cycle a mask is presented it must equal the oldest expected packet.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_mask_q.size() == 0) begin
          check("unexpected_out_valid", MB'(out_valid), MB'(0));
        end else begin
          check("out_mask", out_mask, exp_mask_q[0]);
          check("out_count", MB'(out_count), MB'(exp_cnt_q[0]));
          check("in_ready_in_done", MB'(in_ready), MB'(0));
          if (out_ready) begin
            void'(exp_mask_q.pop_front());
            void'(exp_cnt_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [DB-1:0] q[$];
    logic [MB-1:0] lit;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_flags = '0; in_sel_msb = 1'b0;
    in_osize = 4'b0001; in_vl = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", MB'(in_ready), MB'(0));
    check("rst_out_valid", MB'(out_valid), MB'(0));
    check("rst_out_mask", out_mask, MB'(0));
    check("rst_out_count", MB'(out_count), MB'(0));
    rst = 1'b0;

    // Hand-derived masks pinning the model.
    q = '{16'h0111, 16'h1001};
`ifdef RISCV_V_MASK_TAIL_ONES_EN
    lit = {{122{1'b1}}, 6'h17};
`else
    lit = 128'h17;
`endif
    check("pin_sew32_lo", model(4'b0100, 1'b0, 6, q), lit);
    pkt_fl = q; send_packet(4'b0100, 1'b0, 6, 1'b1);

    q = '{16'h8008};
`ifdef RISCV_V_MASK_TAIL_ONES_EN
    lit = {{124{1'b1}}, 4'h9};
`else
    lit = 128'h9;
`endif
    check("pin_sew32_msb", model(4'b0100, 1'b1, 4, q), lit);
    pkt_fl = q; send_packet(4'b0100, 1'b1, 4, 1'b1);

    q = '{16'hFFFF};
`ifdef RISCV_V_MASK_TAIL_ONES_EN
    lit = {{108{1'b1}}, 20'h000FF};
`else
    lit = 128'hFF;
`endif
    check("pin_early_last", model(4'b0010, 1'b0, 20, q), lit);
    pkt_fl = q; send_packet(4'b0010, 1'b0, 20, 1'b1);

    q = '{16'h1234, 16'hABCD};
`ifdef RISCV_V_MASK_TAIL_ONES_EN
    lit = {{96{1'b1}}, 32'hABCD1234};
`else
    lit = 128'hABCD1234;
`endif
    check("pin_param_change", model(4'b0001, 1'b0, 32, q), lit);
    exp_mask_q.push_back(lit);
    exp_cnt_q.push_back(32);
    drive_beat(16'h1234, 4'b0001, 1'b0, 32, 1'b0);
    drive_beat(16'hABCD, 4'b1000, 1'b1, 2, 1'b0);

    q = '{16'h5A5A};
`ifdef RISCV_V_MASK_TAIL_ONES_EN
    lit = '1;
`else
    lit = '0;
`endif
    check("pin_vl0", model(4'b0001, 1'b0, 0, q), lit);
    pkt_fl = q; send_packet(4'b0001, 1'b0, 0, 1'b1);

    // Full SEW8 mask held through an output stall.
    drain();
    ready_mode = 0;
    pkt_fl.delete();
    for (int k = 0; k < 8; k++) pkt_fl.push_back(16'hFFFF);
    check("pin_full", model(4'b0001, 1'b0, 128, pkt_fl), '1);
    send_packet(4'b0001, 1'b0, 128, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid", MB'(out_valid), MB'(1));
    repeat (3) @(negedge clk);
    ready_mode = 1;
    drain();

    // Reset after the first beat of a two-beat packet discards it.
    drive_beat(16'hFFFF, 4'b0001, 1'b0, 32, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", MB'(out_valid), MB'(0));
    check("midrst_out_mask", out_mask, MB'(0));
    check("midrst_out_count", MB'(out_count), MB'(0));
    rst = 1'b0;
    q = '{16'h00F0};
`ifdef RISCV_V_MASK_TAIL_ONES_EN
    lit = {{112{1'b1}}, 16'h00F0};
`else
    lit = 128'hF0;
`endif
    check("pin_after_rst", model(4'b0001, 1'b0, 16, q), lit);
    pkt_fl = q; send_packet(4'b0001, 1'b0, 16, 1'b0);
    drain();

    ready_mode = 2;
    for (int p = 0; p < 60; p++) begin
      logic [3:0] os;
      bit sel, lastf;
      int vl, epb, vc, need, nb;
      os = 4'b0001 << $urandom_range(0, 3);
      sel = 1'($urandom_range(0, 1));
      vl = $urandom_range(0, 140);
      epb = DB / ebytes(os);
      vc = (vl > MB) ? MB : vl;
      need = (vc == 0) ? 1 : (vc + epb - 1) / epb;
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, need) : need;
      lastf = (nb < need) ? 1'b1 : 1'($urandom_range(0, 1));
      pkt_fl.delete();
      for (int k = 0; k < nb; k++) pkt_fl.push_back(DB'($urandom));
      send_packet(os, sel, vl, lastf);
    end
    ready_mode = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
